// File: rtl/serial_lock_pkg.sv
// Shared types for the serial code lock: controller state encoding and result bit values.
package serial_lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_UNLOCK,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    localparam logic RESULT_UNLOCK = 1'b1;
    localparam logic RESULT_WRONG  = 1'b0;

endpackage

// File: rtl/serial_code_lock_countdown.sv
// lock_countdown: loadable down-counter that holds at zero; done is high while the count is zero.
module lock_countdown #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/serial_code_lock.sv
// Bit-serial unlock controller with runtime code reload and lockout after repeated failures.
// Optional inter-bit inactivity timeout is enabled by defining SERIAL_LOCK_TIMEOUT_EN.
module serial_code_lock
    import serial_lock_pkg::*;
#(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1011,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCKOUT_CYCLES = 16,
    parameter int                  TIMEOUT_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ser_val,
    input  logic                ser_data,
    output logic                ser_ready,
    input  logic                code_load_val,
    input  logic [CODE_LEN-1:0] code_load_data,
    output logic                output_val,
    output logic                output_data,
    output logic                locked_out
);

    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    if (CODE_LEN < 1)       begin : g_bad_len   $error("CODE_LEN must be >= 1");       end
    if (MAX_TRIES < 1)      begin : g_bad_tries $error("MAX_TRIES must be >= 1");      end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lock  $error("LOCKOUT_CYCLES must be >= 1"); end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_to    $error("TIMEOUT_CYCLES must be >= 1"); end

    state_t              state, state_next;
    logic [CODE_LEN-1:0] stored;
    logic [CODE_LEN-1:0] entry;
    logic [CODE_LEN-1:0] entry_shift;
    logic [CW-1:0]       bit_cnt;
    logic [FW-1:0]       fail_cnt;
    logic                accept;
    logic                lock_done;

    assign accept = ser_val && ser_ready;

    if (CODE_LEN == 1) begin : g_shift1
        assign entry_shift = ser_data;
    end else begin : g_shiftn
        assign entry_shift = {entry[CODE_LEN-2:0], ser_data};
    end

    lock_countdown #(.W(LW)) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == S_FAIL) && (state_next == S_LOCKOUT)),
        .load_val (LW'(LOCKOUT_CYCLES - 1)),
        .en       (state == S_LOCKOUT),
        .done     (lock_done)
    );

`ifdef SERIAL_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic idle_done;

    // Reloaded on every accepted bit; expires after TIMEOUT_CYCLES bit-less cycles in COLLECT.
    lock_countdown #(.W(TW)) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (TW'(TIMEOUT_CYCLES - 1)),
        .en       ((state == S_COLLECT) && !accept),
        .done     (idle_done)
    );
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = (CODE_LEN == 1) ? S_CHECK : S_COLLECT;
            end
            S_COLLECT: begin
                if (accept) begin
                    if (bit_cnt == CW'(CODE_LEN - 1)) state_next = S_CHECK;
                end
`ifdef SERIAL_LOCK_TIMEOUT_EN
                else if (idle_done) begin
                    state_next = S_FAIL;
                end
`endif
            end
            S_CHECK:   state_next = (entry == stored) ? S_UNLOCK : S_FAIL;
            S_UNLOCK:  state_next = S_IDLE;
            S_FAIL:    state_next = (fail_cnt == FW'(MAX_TRIES - 1)) ? S_LOCKOUT : S_IDLE;
            S_LOCKOUT: if (lock_done) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            stored      <= DEFAULT_CODE;
            entry       <= '0;
            bit_cnt     <= '0;
            fail_cnt    <= '0;
            ser_ready   <= 1'b1;
            output_val  <= 1'b0;
            output_data <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            state       <= state_next;
            ser_ready   <= (state_next == S_IDLE) || (state_next == S_COLLECT);
            output_val  <= (state_next == S_UNLOCK) || (state_next == S_FAIL);
            output_data <= (state_next == S_UNLOCK) ? RESULT_UNLOCK : RESULT_WRONG;
            locked_out  <= (state_next == S_LOCKOUT);

            if (accept) begin
                entry   <= entry_shift;
                bit_cnt <= bit_cnt + CW'(1);
            end
            // Entry is consumed (or abandoned on timeout) once a result is reported.
            if ((state_next == S_UNLOCK) || (state_next == S_FAIL)) begin
                entry   <= '0;
                bit_cnt <= '0;
            end

            if ((state == S_IDLE) && !accept && code_load_val) stored <= code_load_data;

            case (state)
                S_UNLOCK:  fail_cnt <= '0;
                S_FAIL:    fail_cnt <= fail_cnt + FW'(1);
                S_LOCKOUT: if (state_next == S_IDLE) fail_cnt <= '0;
                default:   ;
            endcase
        end
    end

endmodule
